// File: rtl/pipeline_alu_param.sv
// Two-stage pipelined ALU with internal register file, data memory, valid/ready handshake and forwarding.
// Define PIPELINE_ALU_FLAGS_EN to add the registered flag_z/flag_c/flag_v outputs.
module pipeline_alu_param #(
  parameter int DATA_W     = 16,
  parameter int REG_ADDR_W = 4,
  parameter int MEM_ADDR_W = 8,
  parameter int FUNC_W     = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] rs1,
  input  logic [REG_ADDR_W-1:0] rs2,
  input  logic [REG_ADDR_W-1:0] rd,
  input  logic [FUNC_W-1:0]     func,
  input  logic [MEM_ADDR_W-1:0] addr,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     Z_out,
  input  logic                  ld_en,
  input  logic [REG_ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0]     ld_data,
  input  logic [MEM_ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0]     mem_rd_data
`ifdef PIPELINE_ALU_FLAGS_EN
  ,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  flag_v
`endif
);

  localparam int NumRegs = 1 << REG_ADDR_W;
  localparam int NumMem  = 1 << MEM_ADDR_W;

  logic [DATA_W-1:0] regFile_q [NumRegs];
  logic [DATA_W-1:0] mem_q     [NumMem];

  logic [DATA_W-1:0]     opA_q, opA_d, opB_q, opB_d;
  logic [REG_ADDR_W-1:0] rd_q, rd_d;
  logic [FUNC_W-1:0]     func_q, func_d;
  logic [MEM_ADDR_W-1:0] addr1_q, addr1_d;
  logic                  v1_q, v1_d;

  logic [DATA_W-1:0]     z_q, z_d;
  logic [MEM_ADDR_W-1:0] addr2_q, addr2_d;
  logic                  v2_q, v2_d;

  logic              stall;
  logic              wbFire;
  logic [DATA_W-1:0] aluRes;
  logic [DATA_W-1:0] fwdA, fwdB;

  assign stall     = v2_q && !out_ready;
  assign wbFire    = v1_q && !stall;
  assign in_ready  = !rst_n || !stall;
  assign out_valid = v2_q;
  assign Z_out     = z_q;
  assign mem_rd_data = mem_q[mem_rd_addr];

  always_comb begin
    aluRes = '0;
    case (func_q)
      FUNC_W'(0):  aluRes = opA_q + opB_q;
      FUNC_W'(1):  aluRes = opA_q - opB_q;
      FUNC_W'(2):  aluRes = opA_q * opB_q;
      FUNC_W'(3):  aluRes = opA_q;
      FUNC_W'(4):  aluRes = opB_q;
      FUNC_W'(5):  aluRes = opA_q & opB_q;
      FUNC_W'(6):  aluRes = opA_q | opB_q;
      FUNC_W'(7):  aluRes = opA_q ^ opB_q;
      FUNC_W'(8):  aluRes = '0 - opA_q;
      FUNC_W'(9):  aluRes = '0 - opB_q;
      FUNC_W'(10): aluRes = opA_q >> 1;
      FUNC_W'(11): aluRes = opA_q << 1;
      default:     aluRes = '0;
    endcase
  end

  // Operand sources: in-flight S1 result first, then the load port, then the register file.
  always_comb begin
    fwdA = regFile_q[rs1];
    fwdB = regFile_q[rs2];
    if (ld_en && ld_addr == rs1) fwdA = ld_data;
    if (ld_en && ld_addr == rs2) fwdB = ld_data;
    if (wbFire && rd_q == rs1) fwdA = aluRes;
    if (wbFire && rd_q == rs2) fwdB = aluRes;
  end

  always_comb begin
    opA_d   = opA_q;
    opB_d   = opB_q;
    rd_d    = rd_q;
    func_d  = func_q;
    addr1_d = addr1_q;
    v1_d    = v1_q;
    z_d     = z_q;
    addr2_d = addr2_q;
    v2_d    = v2_q;
    if (!stall) begin
      opA_d   = fwdA;
      opB_d   = fwdB;
      rd_d    = rd;
      func_d  = func;
      addr1_d = addr;
      v1_d    = in_valid;
      z_d     = aluRes;
      addr2_d = addr1_q;
      v2_d    = v1_q;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      opA_q   <= '0;
      opB_q   <= '0;
      rd_q    <= '0;
      func_q  <= '0;
      addr1_q <= '0;
      v1_q    <= 1'b0;
      z_q     <= '0;
      addr2_q <= '0;
      v2_q    <= 1'b0;
    end else begin
      opA_q   <= opA_d;
      opB_q   <= opB_d;
      rd_q    <= rd_d;
      func_q  <= func_d;
      addr1_q <= addr1_d;
      v1_q    <= v1_d;
      z_q     <= z_d;
      addr2_q <= addr2_d;
      v2_q    <= v2_d;
    end
  end

  // The later pipeline write wins over the load port when both target one register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) regFile_q[i] <= '0;
    end else begin
      if (ld_en) regFile_q[ld_addr] <= ld_data;
      if (wbFire) regFile_q[rd_q] <= aluRes;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && v2_q && out_ready) mem_q[addr2_q] <= z_q;
  end

`ifdef PIPELINE_ALU_FLAGS_EN
  logic flagZ_q, flagZ_d, flagC_q, flagC_d, flagV_q, flagV_d;
  logic aluC, aluV;

  // Add carry shows as a wrapped sum smaller than A; sub carry is the borrow.
  always_comb begin
    aluC = 1'b0;
    aluV = 1'b0;
    if (func_q == FUNC_W'(0)) begin
      aluC = aluRes < opA_q;
      aluV = (opA_q[DATA_W-1] == opB_q[DATA_W-1]) && (aluRes[DATA_W-1] != opA_q[DATA_W-1]);
    end else if (func_q == FUNC_W'(1)) begin
      aluC = opA_q < opB_q;
      aluV = (opA_q[DATA_W-1] != opB_q[DATA_W-1]) && (aluRes[DATA_W-1] != opA_q[DATA_W-1]);
    end
  end

  always_comb begin
    flagZ_d = flagZ_q;
    flagC_d = flagC_q;
    flagV_d = flagV_q;
    if (!stall) begin
      flagZ_d = (aluRes == '0);
      flagC_d = aluC;
      flagV_d = aluV;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      flagZ_q <= 1'b0;
      flagC_q <= 1'b0;
      flagV_q <= 1'b0;
    end else begin
      flagZ_q <= flagZ_d;
      flagC_q <= flagC_d;
      flagV_q <= flagV_d;
    end
  end

  assign flag_z = flagZ_q;
  assign flag_c = flagC_q;
  assign flag_v = flagV_q;
`endif

endmodule

// File: tb/tb_pipeline_alu_param.sv
// Directed bench for pipeline_alu_param: reset, forwarding, backpressure, wrap, load collisions, mid-flight reset.
module tb_pipeline_alu_param;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready, ld_en;
  logic [3:0]  rs1, rs2, rd, func, ld_addr;
  logic [7:0]  addr, mem_rd_addr;
  logic [15:0] Z_out, ld_data, mem_rd_data;
`ifdef PIPELINE_ALU_FLAGS_EN
  logic        flag_z, flag_c, flag_v;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  pipeline_alu_param dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .rd(rd), .func(func), .addr(addr),
    .out_valid(out_valid), .out_ready(out_ready), .Z_out(Z_out),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data)
`ifdef PIPELINE_ALU_FLAGS_EN
    , .flag_z(flag_z), .flag_c(flag_c), .flag_v(flag_v)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] s1, input logic [3:0] s2, input logic [3:0] d,
                       input logic [3:0] f, input logic [7:0] a);
    in_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; func = f; addr = a;
  endtask

  task automatic idle;
    in_valid = 1'b0;
  endtask

  task automatic load(input logic [3:0] r, input logic [15:0] v);
    ld_en = 1'b1; ld_addr = r; ld_data = v;
    tick();
    ld_en = 1'b0;
  endtask

  task automatic read_reg(input logic [3:0] r, output logic [15:0] val, output logic vld);
    issue(r, r, r, 4'd3, 8'hF0);
    tick();
    idle();
    tick();
    val = Z_out;
    vld = out_valid;
    tick();
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [15:0] v);
    mem_rd_addr = a;
    #1;
    v = mem_rd_data;
  endtask

  task automatic test_reset;
    logic [15:0] v;
    logic vld;
    rst_n = 1'b0;
    tick();
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready_during: got %b want 1", in_ready); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL rst_out_valid: got %b want 0", out_valid); end
    total++; if (Z_out !== 16'h0000) begin bad++; $display("[TB] FAIL rst_z: got %h want 0000", Z_out); end
    rst_n = 1'b1;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL rst_in_ready_after: got %b want 1", in_ready); end
    read_reg(4'd5, v, vld);
    total++; if (v !== 16'h0000 || vld !== 1'b1) begin bad++; $display("[TB] FAIL rst_r5: got %h/%b want 0000/1", v, vld); end
  endtask

  task automatic test_add;
    logic [15:0] v;
    logic vld;
    load(4'd10, 16'h0005);
    load(4'd5, 16'h0003);
    issue(4'd10, 4'd5, 4'd3, 4'd0, 8'h0A);
    tick();
    idle();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_early_valid: got %b want 0", out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h0008) begin bad++; $display("[TB] FAIL add_result: got %h/%b want 0008/1", Z_out, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL add_valid_drop: got %b want 0", out_valid); end
    read_mem(8'h0A, v);
    total++; if (v !== 16'h0008) begin bad++; $display("[TB] FAIL add_mem: got %h want 0008", v); end
    read_reg(4'd3, v, vld);
    total++; if (v !== 16'h0008) begin bad++; $display("[TB] FAIL add_r3: got %h want 0008", v); end
  endtask

  task automatic test_back_to_back;
    logic [15:0] v;
    load(4'd3, 16'h0000);
    issue(4'd10, 4'd5, 4'd3, 4'd0, 8'h0A);
    tick();
    issue(4'd3, 4'd5, 4'd4, 4'd1, 8'h14);
    tick();
    idle();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h0008) begin bad++; $display("[TB] FAIL b2b_first: got %h/%b want 0008/1", Z_out, out_valid); end
    tick();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h0005) begin bad++; $display("[TB] FAIL b2b_second: got %h/%b want 0005/1", Z_out, out_valid); end
    tick();
    read_mem(8'h14, v);
    total++; if (v !== 16'h0005) begin bad++; $display("[TB] FAIL b2b_mem: got %h want 0005", v); end
  endtask

  task automatic test_backpressure;
    logic [15:0] v;
    logic vld;
    issue(4'd0, 4'd0, 4'd0, 4'd15, 8'h30);
    tick();
    issue(4'd0, 4'd0, 4'd0, 4'd15, 8'h31);
    tick();
    idle();
    tick();
    tick();
    load(4'd1, 16'h0010);
    load(4'd2, 16'h0002);
    issue(4'd1, 4'd2, 4'd7, 4'd0, 8'h30);
    tick();
    issue(4'd1, 4'd2, 4'd8, 4'd2, 8'h31);
    out_ready = 1'b0;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      total++; if (in_ready !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready[%0d]: got %b want 0", i, in_ready); end
      total++; if (out_valid !== 1'b1 || Z_out !== 16'h0012) begin bad++; $display("[TB] FAIL bp_hold[%0d]: got %h/%b want 0012/1", i, Z_out, out_valid); end
      read_mem(8'h30, v);
      total++; if (v !== 16'h0000) begin bad++; $display("[TB] FAIL bp_no_write[%0d]: got %h want 0000", i, v); end
      tick();
    end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h0020) begin bad++; $display("[TB] FAIL bp_drain2: got %h/%b want 0020/1", Z_out, out_valid); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL bp_empty: got %b want 0", out_valid); end
    read_mem(8'h30, v);
    total++; if (v !== 16'h0012) begin bad++; $display("[TB] FAIL bp_mem30: got %h want 0012", v); end
    read_mem(8'h31, v);
    total++; if (v !== 16'h0020) begin bad++; $display("[TB] FAIL bp_mem31: got %h want 0020", v); end
    read_reg(4'd8, v, vld);
    total++; if (v !== 16'h0020) begin bad++; $display("[TB] FAIL bp_r8: got %h want 0020", v); end
  endtask

  task automatic test_wrap;
    logic [3:0]  fn [14] = '{4'd0, 4'd2, 4'd15, 4'd8, 4'd1, 4'd10, 4'd11, 4'd9, 4'd7, 4'd5, 4'd6, 4'd4, 4'd3, 4'd0};
    logic [3:0]  ra [14] = '{4'd1, 4'd11, 4'd1, 4'd2, 4'd2, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd1, 4'd13};
    logic [3:0]  rb [14] = '{4'd2, 4'd11, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd1, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2, 4'd2};
    logic [15:0] ex [14] = '{16'h0000, 16'h0000, 16'h0000, 16'hFFFF, 16'h0002, 16'h7FFF, 16'hFFFE,
                             16'h0001, 16'hFFFE, 16'h0001, 16'hFFFF, 16'h0001, 16'hFFFF, 16'h8000};
    logic        ec [14] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        ev [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    load(4'd1, 16'hFFFF);
    load(4'd2, 16'h0001);
    load(4'd11, 16'h0100);
    load(4'd13, 16'h7FFF);
    for (int i = 0; i <= 14; i++) begin
      if (i < 14) issue(ra[i], rb[i], 4'd12, fn[i], 8'(8'h50 + i));
      else idle();
      tick();
      if (i >= 1) begin
        total++; if (out_valid !== 1'b1 || Z_out !== ex[i-1]) begin bad++; $display("[TB] FAIL wrap[%0d]: got %h/%b want %h/1", i-1, Z_out, out_valid, ex[i-1]); end
`ifdef PIPELINE_ALU_FLAGS_EN
        total++; if ({flag_z, flag_c, flag_v} !== {ex[i-1] == 16'h0000, ec[i-1], ev[i-1]}) begin
          bad++; $display("[TB] FAIL wrap_flags[%0d]: got zcv=%b%b%b want %b%b%b", i-1, flag_z, flag_c, flag_v, ex[i-1] == 16'h0000, ec[i-1], ev[i-1]);
        end
`else
        if (ec[i-1] === 1'bx || ev[i-1] === 1'bx) $display("[TB] note: flag table entry unknown at %0d", i-1);
`endif
      end
    end
    tick();
  endtask

  task automatic test_collision;
    logic [15:0] v;
    logic vld;
    load(4'd3, 16'h0000);
    issue(4'd10, 4'd5, 4'd3, 4'd0, 8'h62);
    tick();
    idle();
    ld_en = 1'b1; ld_addr = 4'd3; ld_data = 16'h1234;
    tick();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h0008) begin bad++; $display("[TB] FAIL coll_add: got %h/%b want 0008/1", Z_out, out_valid); end
    ld_addr = 4'd6; ld_data = 16'hBEEF;
    issue(4'd6, 4'd6, 4'd14, 4'd0, 8'h61);
    tick();
    ld_en = 1'b0;
    idle();
    tick();
    total++; if (out_valid !== 1'b1 || Z_out !== 16'h7DDE) begin bad++; $display("[TB] FAIL coll_ld_fwd: got %h/%b want 7DDE/1", Z_out, out_valid); end
    tick();
    read_reg(4'd3, v, vld);
    total++; if (v !== 16'h0008) begin bad++; $display("[TB] FAIL coll_r3: got %h want 0008", v); end
    read_reg(4'd6, v, vld);
    total++; if (v !== 16'hBEEF) begin bad++; $display("[TB] FAIL coll_r6: got %h want BEEF", v); end
  endtask

  task automatic test_reset_midflight;
    logic [15:0] v;
    logic vld;
    issue(4'd10, 4'd10, 4'd15, 4'd3, 8'h70);
    tick();
    issue(4'd10, 4'd10, 4'd15, 4'd3, 8'h71);
    tick();
    idle();
    tick();
    tick();
    issue(4'd10, 4'd5, 4'd15, 4'd0, 8'h70);
    tick();
    issue(4'd10, 4'd5, 4'd15, 4'd1, 8'h71);
    tick();
    idle();
    rst_n = 1'b0;
    out_ready = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_in_ready_rst: got %b want 1", in_ready); end
    out_ready = 1'b1;
    tick();
    rst_n = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || Z_out !== 16'h0000 || in_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL mid_after_rst: got z=%h v=%b rdy=%b want 0000/0/1", Z_out, out_valid, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("[TB] FAIL mid_discard: got %b want 0", out_valid); end
    read_mem(8'h70, v);
    total++; if (v !== 16'h0005) begin bad++; $display("[TB] FAIL mid_mem70: got %h want 0005", v); end
    read_mem(8'h71, v);
    total++; if (v !== 16'h0005) begin bad++; $display("[TB] FAIL mid_mem71: got %h want 0005", v); end
    for (int r = 0; r < 16; r++) begin
      read_reg(4'(r), v, vld);
      total++; if (v !== 16'h0000 || vld !== 1'b1) begin bad++; $display("[TB] FAIL mid_reg[%0d]: got %h/%b want 0000/1", r, v, vld); end
    end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; ld_en = 1'b0;
    rs1 = '0; rs2 = '0; rd = '0; func = '0; addr = '0;
    ld_addr = '0; ld_data = '0; mem_rd_addr = '0;
    test_reset();
    test_add();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_collision();
    test_reset_midflight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
